// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller for the 5-stage RV32 core.
//               It combines the load-use stall request from the ID-stage
//               forwarding unit with the branch/jump redirect from EX, and
//               drives the PC and IF/ID write enables and the IF/ID and
//               ID/EX flushes. A RUN/STALL/FLUSH state machine tracks
//               stall and flush episodes. A stall watchdog raises a sticky
//               error, and optional performance counters are provided.
// Config      : `define HAZARD_PERF_CNT_EN to build the stall/redirect
//               performance counters. When it is undefined, stall_cnt and
//               flush_cnt are tied to 0 and no counter registers exist.
// Ports       : cpu_clk, cpu_rst         clock, synchronous active-high reset
//               suspend, load_use        load-use stall request (both needed)
//               ex_redirect, ex_target   taken branch / jal / jalr from EX
//               pc_we, npc_redirect,     PC write enable and next-PC select
//               redirect_pc              next-PC value (0 unless redirecting)
//               ifid_we, ifid_flush      IF/ID hold and NOP injection
//               idex_flush               ID/EX bubble injection
//               state                    RUN=0, STALL=1, FLUSH=2
//               stall_err                sticky watchdog error
//               stall_cnt, flush_cnt     performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int STALL_MAX = 4
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        suspend,
  input  logic        load_use,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic        pc_we,
  output logic        npc_redirect,
  output logic [31:0] redirect_pc,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic [1:0]  state,
  output logic        stall_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  // The run counter must hold STALL_MAX+1 so it can saturate just past the
  // error threshold. It is never narrower than 3 bits.
  localparam int c_run_w = ($clog2(STALL_MAX + 2) < 3) ? 3 : $clog2(STALL_MAX + 2);
  localparam logic [c_run_w-1:0] c_stall_max = c_run_w'(STALL_MAX);
  localparam logic [c_run_w-1:0] c_run_sat   = c_run_w'(STALL_MAX + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_run_w-1:0]   r_run_cnt;
  logic                 r_stall_err;

  logic w_redir;
  logic w_stall_req;
  logic w_stall_cycle;

  // While in FLUSH, ID holds a bubble, so a suspend from it is meaningless.
  assign w_redir       = ex_redirect;
  assign w_stall_req   = suspend && load_use && (r_state != ST_FLUSH);
  // A redirect wins over a stall: the ID instruction is wrong-path.
  assign w_stall_cycle = w_stall_req && !w_redir;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and combinational pipeline controls
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = ST_RUN;
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    npc_redirect = 1'b0;
    redirect_pc  = 32'h0;

    // RUN, STALL and FLUSH share the same priority ordering. FLUSH cannot
    // reach STALL only because the stall request is masked there.
    if (w_redir) begin
      w_state_nxt = ST_FLUSH;
    end else if (w_stall_req) begin
      w_state_nxt = ST_STALL;
    end else begin
      w_state_nxt = ST_RUN;
    end

    if (cpu_rst) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
    end else if (w_redir) begin
      npc_redirect = 1'b1;
      redirect_pc  = ex_target;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
    end else if (w_stall_req) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_flush   = 1'b1;
    end
  end

  assign state = r_state;

  // --------------------------------------------------------------------------
  // Stall watchdog: counts consecutive stall cycles and latches an error
  // once a stall would run past STALL_MAX. Report-only; stalling continues.
  // --------------------------------------------------------------------------
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_run_cnt   <= '0;
      r_stall_err <= 1'b0;
    end else if (w_stall_cycle) begin
      if (r_run_cnt < c_run_sat) begin
        r_run_cnt <= r_run_cnt + 1'b1;
      end
      if (r_run_cnt >= c_stall_max) begin
        r_stall_err <= 1'b1;
      end
    end else begin
      r_run_cnt <= '0;
    end
  end

  assign stall_err = r_stall_err;

  // --------------------------------------------------------------------------
  // Performance counters (saturating)
  // --------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_stall_cnt <= 32'h0;
      r_flush_cnt <= 32'h0;
    end else begin
      if (w_stall_cycle && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'h1;
      end
      if (w_redir && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'h1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = 32'h0;
  assign flush_cnt = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl (STALL_MAX=4).
//               Expected counter values follow HAZARD_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit c_perf = 1'b1;
`else
  localparam bit c_perf = 1'b0;
`endif

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        suspend;
  logic        load_use;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        pc_we;
  logic        npc_redirect;
  logic [31:0] redirect_pc;
  logic        ifid_we;
  logic        ifid_flush;
  logic        idex_flush;
  logic [1:0]  state;
  logic        stall_err;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.STALL_MAX(4)) dut (
    .cpu_clk      (cpu_clk),
    .cpu_rst      (cpu_rst),
    .suspend      (suspend),
    .load_use     (load_use),
    .ex_redirect  (ex_redirect),
    .ex_target    (ex_target),
    .pc_we        (pc_we),
    .npc_redirect (npc_redirect),
    .redirect_pc  (redirect_pc),
    .ifid_we      (ifid_we),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .state        (state),
    .stall_err    (stall_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after the falling edge; combinational outputs settle by #1.
  task automatic drive(input logic rst, input logic sus, input logic lu,
                       input logic red, input logic [31:0] tgt);
    @(negedge cpu_clk);
    cpu_rst     = rst;
    suspend     = sus;
    load_use    = lu;
    ex_redirect = red;
    ex_target   = tgt;
    #1;
  endtask

  // Let the rising edge register the current cycle, then sample.
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  function automatic logic [31:0] perf(input int n);
    return c_perf ? 32'(n) : 32'h0;
  endfunction

  initial begin
    cpu_rst = 1'b1; suspend = 1'b0; load_use = 1'b0;
    ex_redirect = 1'b0; ex_target = 32'h0;

    // Reset held two cycles with random requests.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      chk("rst_pc_we",        32'(pc_we),        32'h0);
      chk("rst_ifid_we",      32'(ifid_we),      32'h0);
      chk("rst_ifid_flush",   32'(ifid_flush),   32'h1);
      chk("rst_idex_flush",   32'(idex_flush),   32'h1);
      chk("rst_npc_redirect", 32'(npc_redirect), 32'h0);
      chk("rst_redirect_pc",  redirect_pc,       32'h0);
      tick();
    end

    // Release, no requests.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("idle_state",      32'(state),      32'h0);
    chk("idle_pc_we",      32'(pc_we),      32'h1);
    chk("idle_ifid_we",    32'(ifid_we),    32'h1);
    chk("idle_flushes",    {30'h0, ifid_flush, idex_flush}, 32'h0);
    chk("idle_stall_err",  32'(stall_err),  32'h0);
    chk("idle_stall_cnt",  stall_cnt,       32'h0);
    chk("idle_flush_cnt",  flush_cnt,       32'h0);

    // Single load-use.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("lu_pc_we",      32'(pc_we),      32'h0);
    chk("lu_ifid_we",    32'(ifid_we),    32'h0);
    chk("lu_idex_flush", 32'(idex_flush), 32'h1);
    chk("lu_ifid_flush", 32'(ifid_flush), 32'h0);
    chk("lu_npc_redir",  32'(npc_redirect), 32'h0);
    tick();
    chk("lu_state_stall", 32'(state),  32'h1);
    chk("lu_stall_cnt",   stall_cnt,   perf(1));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("lu_after_pc_we", 32'(pc_we), 32'h1);
    tick();
    chk("lu_state_run", 32'(state), 32'h0);

    // Redirect beats a concurrent stall request.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
    chk("rd_npc_redirect", 32'(npc_redirect), 32'h1);
    chk("rd_redirect_pc",  redirect_pc,       32'h0000_0100);
    chk("rd_pc_we",        32'(pc_we),        32'h1);
    chk("rd_ifid_we",      32'(ifid_we),      32'h1);
    chk("rd_ifid_flush",   32'(ifid_flush),   32'h1);
    chk("rd_idex_flush",   32'(idex_flush),   32'h1);
    tick();
    chk("rd_state_flush", 32'(state), 32'h2);
    chk("rd_stall_cnt",   stall_cnt,  perf(1));
    chk("rd_flush_cnt",   flush_cnt,  perf(1));

    // Stall request masked while in FLUSH.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0100);
    chk("mask_pc_we",       32'(pc_we),      32'h1);
    chk("mask_ifid_we",     32'(ifid_we),    32'h1);
    chk("mask_idex_flush",  32'(idex_flush), 32'h0);
    chk("mask_redirect_pc", redirect_pc,     32'h0);
    tick();
    chk("mask_state_run", 32'(state), 32'h0);
    chk("mask_stall_cnt", stall_cnt,  perf(1));

    // Back-to-back redirects each flush and count.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300);
    chk("b2b_npc_redirect", 32'(npc_redirect), 32'h1);
    chk("b2b_redirect_pc",  redirect_pc,       32'h0000_0300);
    chk("b2b_ifid_flush",   32'(ifid_flush),   32'h1);
    tick();
    chk("b2b_state",     32'(state), 32'h2);
    chk("b2b_flush_cnt", flush_cnt,  perf(3));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("b2b_state_run", 32'(state), 32'h0);

    // suspend without load_use qualifier.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("nq_pc_we",      32'(pc_we),      32'h1);
    chk("nq_idex_flush", 32'(idex_flush), 32'h0);
    tick();
    chk("nq_state", 32'(state), 32'h0);

    // Watchdog: five consecutive stall cycles with STALL_MAX=4.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("wd_pc_we", 32'(pc_we), 32'h0);
      tick();
      chk("wd_state", 32'(state), 32'h1);
      chk($sformatf("wd_err_after_%0d", i + 1), 32'(stall_err), (i == 4) ? 32'h1 : 32'h0);
    end
    chk("wd_stall_cnt", stall_cnt, perf(6));
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("wd_idle_pc_we", 32'(pc_we), 32'h1);
      tick();
      chk("wd_err_sticky", 32'(stall_err), 32'h1);
      chk("wd_idle_state", 32'(state),     32'h0);
    end

    // Reset clears the sticky error and counters.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0400);
    chk("rst2_pc_we",        32'(pc_we),        32'h0);
    chk("rst2_npc_redirect", 32'(npc_redirect), 32'h0);
    chk("rst2_idex_flush",   32'(idex_flush),   32'h1);
    tick();
    chk("rst2_stall_err", 32'(stall_err), 32'h0);
    chk("rst2_state",     32'(state),     32'h0);
    chk("rst2_stall_cnt", stall_cnt,      32'h0);
    chk("rst2_flush_cnt", flush_cnt,      32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("rst2_idle_state", 32'(state), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
